// File: rtl/eth_fcs_framer.sv
// eth_fcs_framer: turns the byte_data stream into a GMII transmit stream.
// Pads short frames, appends the CRC-32 FCS and holds off byte_data for the inter-frame gap.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for in_valid; first accepted byte starts the preamble
// PRE   | passing preamble/SFD through untouched, no CRC, no length
// BODY  | passing header/payload, CRC and length updated per byte
// PAD   | inserting 0x00 bytes until the minimum body length is reached
// FCS   | emitting the inverted CRC, least significant byte first
// IFG   | forced idle on the line; byte_data held off
module eth_fcs_framer #(
   parameter int PREAMBLE_BYTES  = 8,
   parameter int MIN_FRAME_BYTES = 60,
   parameter int IFG_BYTES       = 12
) (
   input  logic        clk125MHz,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        advance,
   output logic [7:0]  txd,
   output logic        tx_en,
   output logic        tx_er,
   output logic        frame_done,
   output logic [10:0] body_len
);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_BODY, S_PAD, S_FCS, S_IFG} state_t;

   localparam logic [7:0]  LP_PRE      = 8'(PREAMBLE_BYTES);
   localparam logic [10:0] LP_MIN      = 11'(MIN_FRAME_BYTES);
   localparam logic [7:0]  LP_IFG_LAST = 8'(IFG_BYTES - 1);

   state_t      r_state, w_state_nxt;
   logic [7:0]  r_pre_cnt;
   logic [10:0] r_len;
   logic [1:0]  r_fcs_cnt;
   logic [7:0]  r_ifg_cnt;
   logic [31:0] r_crc;
   logic [7:0]  r_txd;
   logic        r_tx_en, r_tx_er, r_done;
   logic [10:0] r_body_len;

   logic [7:0]  w_txd_d, w_crc_data, w_fcs_byte;
   logic        w_tx_en_d, w_tx_er_d, w_done_d;
   logic        w_crc_en, w_len_en, w_pre_inc, w_fcs_emit, w_clr;
   logic [10:0] w_len_inc;
   logic        w_pad_last;
   logic [31:0] w_crc_inv;

   // Reflected CRC-32 (0xEDB88320), one byte per call, LSB first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] c_in, input logic [7:0] d);
      logic [31:0] c;
      c = c_in ^ {24'd0, d};
      for (int i = 0; i < 8; i++)
         c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      return c;
   endfunction

   assign w_len_inc  = (r_len == 11'h7FF) ? r_len : r_len + 11'd1;
   assign w_pad_last = (w_len_inc >= LP_MIN);
   assign w_crc_inv  = ~r_crc;
   assign w_clr      = (r_state != S_IDLE) && (w_state_nxt == S_IDLE);

   // byte_data may only move while a frame is being accepted
   assign advance    = (r_state == S_IDLE) || (r_state == S_PRE) || (r_state == S_BODY);
   assign txd        = r_txd;
   assign tx_en      = r_tx_en;
   assign tx_er      = r_tx_er;
   assign frame_done = r_done;
   assign body_len   = r_body_len;

   // FCS byte currently due on the line
   always_comb begin
      case (r_fcs_cnt)
         2'd0:    w_fcs_byte = w_crc_inv[7:0];
         2'd1:    w_fcs_byte = w_crc_inv[15:8];
         2'd2:    w_fcs_byte = w_crc_inv[23:16];
         default: w_fcs_byte = w_crc_inv[31:24];
      endcase
   end

   // State register
   always_ff @(posedge clk125MHz or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next-state logic; the end-of-body cycle already emits the first pad or FCS byte so tx_en never gaps
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (in_valid) w_state_nxt = (LP_PRE <= 8'd1) ? S_BODY : S_PRE;
         S_PRE: begin
            if (!in_valid)                        w_state_nxt = S_IFG;
            else if (r_pre_cnt + 8'd1 >= LP_PRE)  w_state_nxt = S_BODY;
         end
         S_BODY: begin
            if (!in_valid)
               w_state_nxt = (r_len < LP_MIN && !w_pad_last) ? S_PAD : S_FCS;
         end
         S_PAD:   if (w_pad_last) w_state_nxt = S_FCS;
         S_FCS:   if (r_fcs_cnt == 2'd3) w_state_nxt = (IFG_BYTES == 0) ? S_IDLE : S_IFG;
         S_IFG:   if (r_ifg_cnt == LP_IFG_LAST) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output and datapath control decode
   always_comb begin
      w_txd_d    = 8'h00;
      w_tx_en_d  = 1'b0;
      w_tx_er_d  = 1'b0;
      w_done_d   = 1'b0;
      w_crc_en   = 1'b0;
      w_crc_data = 8'h00;
      w_len_en   = 1'b0;
      w_pre_inc  = 1'b0;
      w_fcs_emit = 1'b0;
      case (r_state)
         S_IDLE, S_PRE: begin
            if (in_valid) begin
               w_txd_d   = in_data;
               w_tx_en_d = 1'b1;
               w_pre_inc = 1'b1;
            end else if (r_state == S_PRE) begin
               w_tx_er_d = 1'b1;
            end
         end
         S_BODY: begin
            if (in_valid) begin
               w_txd_d    = in_data;
               w_tx_en_d  = 1'b1;
               w_crc_en   = 1'b1;
               w_crc_data = in_data;
               w_len_en   = 1'b1;
            end else if (r_len < LP_MIN) begin
               w_tx_en_d = 1'b1;
               w_crc_en  = 1'b1;
               w_len_en  = 1'b1;
            end else begin
               w_fcs_emit = 1'b1;
            end
         end
         S_PAD: begin
            w_tx_en_d = 1'b1;
            w_crc_en  = 1'b1;
            w_len_en  = 1'b1;
         end
         S_FCS:   w_fcs_emit = 1'b1;
         default: ;
      endcase
      if (w_fcs_emit) begin
         w_txd_d   = w_fcs_byte;
         w_tx_en_d = 1'b1;
         w_done_d  = (r_fcs_cnt == 2'd3);
      end
   end

   // Registered outputs, CRC and counters; everything clears on the return to IDLE
   always_ff @(posedge clk125MHz or negedge rst) begin
      if (!rst) begin
         r_txd      <= 8'h00;
         r_tx_en    <= 1'b0;
         r_tx_er    <= 1'b0;
         r_done     <= 1'b0;
         r_body_len <= 11'd0;
         r_crc      <= 32'hFFFF_FFFF;
         r_len      <= 11'd0;
         r_pre_cnt  <= 8'd0;
         r_fcs_cnt  <= 2'd0;
         r_ifg_cnt  <= 8'd0;
      end else begin
         r_txd   <= w_txd_d;
         r_tx_en <= w_tx_en_d;
         r_tx_er <= w_tx_er_d;
         r_done  <= w_done_d;
         if (w_fcs_emit && r_fcs_cnt == 2'd0) r_body_len <= r_len;
         if (w_clr) begin
            r_crc     <= 32'hFFFF_FFFF;
            r_len     <= 11'd0;
            r_pre_cnt <= 8'd0;
            r_fcs_cnt <= 2'd0;
            r_ifg_cnt <= 8'd0;
         end else begin
            if (w_crc_en)            r_crc     <= crc32_byte(r_crc, w_crc_data);
            if (w_len_en)            r_len     <= w_len_inc;
            if (w_pre_inc)           r_pre_cnt <= r_pre_cnt + 8'd1;
            if (w_fcs_emit)          r_fcs_cnt <= r_fcs_cnt + 2'd1;
            if (r_state == S_IFG)    r_ifg_cnt <= r_ifg_cnt + 8'd1;
         end
      end
   end

endmodule
